// File: rtl/fc_result_writer.sv
// fc_result_writer: captures FC-layer output vectors into a 2-entry FIFO, splits
// each vector into DAT_W-bit words and writes them sequentially into the result
// BRAM. After BATCH_NUM vectors it raises batch_done and waits for host_ack.
//
// Handshake: out_valid is a one-cycle pulse with no back-pressure. A vector is
// accepted when the FIFO has room (or a slot frees in the same cycle); otherwise
// it is dropped and the sticky overflow flag is set. host_ack is a one-cycle
// pulse that only has an effect while batch_done is high.
module fc_result_writer #(
    parameter int DIM_OUTPUT = 8,
    parameter int OUTPUT_W   = 8,
    parameter int DAT_W      = 32,
    parameter int ADDR_SW    = 14,
    parameter int BATCH_NUM  = 320,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           out_valid,
    input  logic [DIM_OUTPUT*OUTPUT_W-1:0] out_dat,
    output logic [ADDR_SW-1:0]             wr_addr,
    output logic [DAT_W-1:0]               wr_din,
    output logic                           wr_en,
    output logic                           wr_we,
    input  logic                           host_ack,
    output logic                           batch_done,
    output logic                           overflow,
    output logic                           busy,
    output logic [1:0]                     state_dbg
);

    localparam int VEC_W  = DIM_OUTPUT * OUTPUT_W;
    localparam int WPV    = VEC_W / DAT_W;
    localparam int WIDX_W = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int VCNT_W = $clog2(BATCH_NUM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [WIDX_W-1:0]   word_idx, word_idx_next;
    logic [VCNT_W-1:0]   vec_cnt, vec_cnt_next;

    logic [VEC_W-1:0]    fifo_mem [2];
    logic                rd_ptr, wr_ptr;
    logic [1:0]          fifo_cnt, fifo_cnt_next;
    logic                fifo_empty, fifo_full;

    logic [VEC_W-1:0]    head;
    logic [DAT_W-1:0]    head_words [WPV];
    logic [DAT_W-1:0]    cur_word;
    logic [ADDR_SW-1:0]  addr_now;
    logic                issue, last_word, pop, push, drop, batch_end;

    assign state_dbg = state;

    // FIFO status, word selection and the push/pop decisions for this cycle.
    always_comb begin
        fifo_empty = (fifo_cnt == 2'd0);
        fifo_full  = (fifo_cnt == 2'd2);
        head       = fifo_mem[rd_ptr];
        for (int w = 0; w < WPV; w++) begin
            head_words[w] = head[w*DAT_W +: DAT_W];
        end
        cur_word   = head_words[word_idx];
        // Draining is paused while the batch waits for the host.
        issue      = (state != DONE) && !fifo_empty;
        last_word  = (word_idx == WIDX_W'(WPV - 1));
        pop        = issue && last_word;
        // A full FIFO still accepts a vector when the head leaves this cycle.
        push       = out_valid && (!fifo_full || pop);
        drop       = out_valid && !push;
        batch_end  = pop && (vec_cnt == VCNT_W'(BATCH_NUM - 1));
        // Address arithmetic is done at ADDR_SW bits so it wraps naturally.
        addr_now   = ADDR_SW'(BASE_ADDR) + ADDR_SW'(vec_cnt) * ADDR_SW'(WPV)
                   + ADDR_SW'(word_idx);
        case ({push, pop})
            2'b10:   fifo_cnt_next = fifo_cnt + 2'd1;
            2'b01:   fifo_cnt_next = fifo_cnt - 2'd1;
            default: fifo_cnt_next = fifo_cnt;
        endcase
    end

    // Next-state logic: word/vector counters advance as each word is issued.
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        vec_cnt_next  = vec_cnt;
        case (state)
            IDLE, WRITE: begin
                if (issue) begin
                    if (last_word) begin
                        word_idx_next = '0;
                        vec_cnt_next  = vec_cnt + VCNT_W'(1);
                        if (batch_end) begin
                            state_next = DONE;
                        end else if (fifo_cnt_next != 2'd0) begin
                            state_next = WRITE;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        word_idx_next = word_idx + WIDX_W'(1);
                        state_next    = WRITE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (host_ack) begin
                    vec_cnt_next = '0;
                    state_next   = (fifo_cnt_next != 2'd0) ? WRITE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, FIFO pointers and registered BRAM/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_idx   <= '0;
            vec_cnt    <= '0;
            fifo_cnt   <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            wr_addr    <= '0;
            wr_din     <= '0;
            wr_en      <= 1'b0;
            wr_we      <= 1'b0;
            batch_done <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
            vec_cnt  <= vec_cnt_next;
            fifo_cnt <= fifo_cnt_next;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            wr_en    <= issue;
            wr_we    <= issue;
            if (issue) begin
                wr_din  <= cur_word;
                wr_addr <= addr_now;
            end
            batch_done <= (state_next == DONE);
            overflow   <= overflow | drop;
            busy       <= (fifo_cnt_next != 2'd0) || (state_next != IDLE);
        end
    end

    // FIFO storage; contents are only meaningful behind the counters.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= out_dat;
    end

endmodule

// File: tb/tb_fc_result_writer.sv
// Bench for fc_result_writer. dut0 uses the default parameters; dut1 uses a
// 4-vector batch starting near the top of the address space to exercise the
// batch hold and address wrap together.
module tb_fc_result_writer;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int VW = 64;
    localparam int EW = AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst0, out_valid0, host_ack0;
    logic [VW-1:0] out_dat0;
    logic [AW-1:0] wr_addr0;
    logic [DW-1:0] wr_din0;
    logic          wr_en0, wr_we0, batch_done0, overflow0, busy0;
    logic [1:0]    state_dbg0;

    logic          rst1, out_valid1, host_ack1;
    logic [VW-1:0] out_dat1;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_din1;
    logic          wr_en1, wr_we1, batch_done1, overflow1, busy1;
    logic [1:0]    state_dbg1;

    fc_result_writer dut0 (
        .clk(clk), .rst(rst0), .out_valid(out_valid0), .out_dat(out_dat0),
        .wr_addr(wr_addr0), .wr_din(wr_din0), .wr_en(wr_en0), .wr_we(wr_we0),
        .host_ack(host_ack0), .batch_done(batch_done0), .overflow(overflow0),
        .busy(busy0), .state_dbg(state_dbg0)
    );

    fc_result_writer #(.BATCH_NUM(4), .BASE_ADDR(16380)) dut1 (
        .clk(clk), .rst(rst1), .out_valid(out_valid1), .out_dat(out_dat1),
        .wr_addr(wr_addr1), .wr_din(wr_din1), .wr_en(wr_en1), .wr_we(wr_we1),
        .host_ack(host_ack1), .batch_done(batch_done1), .overflow(overflow1),
        .busy(busy1), .state_dbg(state_dbg1)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int wr_cnt0 = 0, first_cyc0 = 0, last_cyc0 = 0;
    int wr_cnt1 = 0;
    int na0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsz(input int dut);
        return (dut == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Monitor: every presented write is popped from the expected queue.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (!rst0 && wr_en0) begin
            if (wr_cnt0 == 0) first_cyc0 = cyc;
            last_cyc0 = cyc;
            wr_cnt0++;
            check("wr_we0", 64'(wr_we0), 64'd1);
            if (exp_q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr0 addr=%0d din=%0h", wr_addr0, wr_din0);
            end else begin
                e = exp_q0.pop_front();
                check("wr_addr0", 64'(wr_addr0), 64'(e[DW +: AW]));
                check("wr_din0", 64'(wr_din0), 64'(e[DW-1:0]));
            end
        end
        if (!rst1 && wr_en1) begin
            wr_cnt1++;
            check("wr_we1", 64'(wr_we1), 64'd1);
            if (exp_q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr1 addr=%0d din=%0h", wr_addr1, wr_din1);
            end else begin
                e = exp_q1.pop_front();
                check("wr_addr1", 64'(wr_addr1), 64'(e[DW +: AW]));
                check("wr_din1", 64'(wr_din1), 64'(e[DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle out_valid pulse carrying {hi, lo}; expected words are lo then hi.
    task automatic send0(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit accept);
        out_valid0 = 1'b1;
        out_dat0   = {hi, lo};
        if (accept) begin
            exp_q0.push_back({AW'(na0), lo});
            exp_q0.push_back({AW'(na0 + 1), hi});
            na0 = na0 + 2;
        end
        tick();
        out_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [DW-1:0] lo, input logic [DW-1:0] hi, input logic [AW-1:0] addr);
        out_valid1 = 1'b1;
        out_dat1   = {hi, lo};
        exp_q1.push_back({addr, lo});
        exp_q1.push_back({addr + 14'd1, hi});
        tick();
        out_valid1 = 1'b0;
    endtask

    // Bounded wait for the expected queue to shrink to target entries.
    task automatic wait_q(input int dut, input int target, input int max, input string name);
        int n = 0;
        while (qsz(dut) > target && n < max) begin
            tick();
            n++;
        end
        check(name, 64'(qsz(dut)), 64'(target));
    endtask

    // ---------------- stimulus ----------------
    int t_send;
    logic [AW-1:0] addr1_t [5];

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        out_valid0 = 1'b0; out_valid1 = 1'b0;
        host_ack0 = 1'b0; host_ack1 = 1'b0;
        out_dat0 = '0; out_dat1 = '0;
        repeat (3) tick();

        // Reset values.
        check("rst_wr_en0", 64'(wr_en0), 64'd0);
        check("rst_wr_we0", 64'(wr_we0), 64'd0);
        check("rst_wr_addr0", 64'(wr_addr0), 64'd0);
        check("rst_wr_din0", 64'(wr_din0), 64'd0);
        check("rst_batch_done0", 64'(batch_done0), 64'd0);
        check("rst_overflow0", 64'(overflow0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_state0", 64'(state_dbg0), 64'd0);
        check("rst_wr_en1", 64'(wr_en1), 64'd0);
        check("rst_batch_done1", 64'(batch_done1), 64'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        // Single vector: words at t+2 and t+3, busy returns low.
        wr_cnt0 = 0;
        t_send  = cyc;
        send0(32'h04030201, 32'h08070605, 1'b1);
        wait_q(0, 0, 20, "t1_drain");
        check("t1_latency", 64'(first_cyc0 - t_send), 64'd2);
        check("t1_count", 64'(wr_cnt0), 64'd2);
        check("t1_consecutive", 64'(last_cyc0 - first_cyc0), 64'd1);
        repeat (2) tick();
        check("t1_busy", 64'(busy0), 64'd0);

        // Ten vectors every two cycles: 20 gap-free writes.
        wr_cnt0 = 0;
        for (int i = 0; i < 10; i++) begin
            send0(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1);
            tick();
        end
        wait_q(0, 0, 50, "t2_drain");
        check("t2_count", 64'(wr_cnt0), 64'd20);
        check("t2_no_gap", 64'(last_cyc0 - first_cyc0), 64'd19);
        check("t2_overflow", 64'(overflow0), 64'd0);

        // Four consecutive pulses: third accepted via simultaneous pop, fourth dropped.
        repeat (2) tick();
        wr_cnt0 = 0;
        send0(32'h1111_1111, 32'h1212_1212, 1'b1);
        send0(32'h2222_2222, 32'h2323_2323, 1'b1);
        send0(32'h3333_3333, 32'h3434_3434, 1'b1);
        send0(32'h4444_4444, 32'h4545_4545, 1'b0);
        check("t4_overflow_set", 64'(overflow0), 64'd1);
        wait_q(0, 0, 30, "t4_drain");
        check("t4_count", 64'(wr_cnt0), 64'd6);
        repeat (3) tick();
        check("t4_overflow_sticky", 64'(overflow0), 64'd1);

        // Reset between word 0 and word 1.
        send0(32'hDEAD_0000, 32'hDEAD_0001, 1'b1);
        tick();
        check("t6_word0_shown", 64'(wr_en0), 64'd1);
        rst0 = 1'b1;
        #1;
        check("t6_wr_en_async", 64'(wr_en0), 64'd0);
        exp_q0.delete();
        tick();
        rst0 = 1'b0;
        na0  = 0;
        check("t6_batch_done", 64'(batch_done0), 64'd0);
        check("t6_overflow", 64'(overflow0), 64'd0);
        check("t6_busy", 64'(busy0), 64'd0);
        send0(32'hCAFE_0000, 32'hCAFE_0001, 1'b1);
        wait_q(0, 0, 20, "t6_drain");

        // Batch of 4 with wrap; fifth vector held until host_ack.
        addr1_t[0] = 14'd16380; addr1_t[1] = 14'd16382;
        addr1_t[2] = 14'd0;     addr1_t[3] = 14'd2;
        addr1_t[4] = 14'd16380;
        wr_cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            send1(32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i), addr1_t[i]);
            tick();
        end
        wait_q(1, 2, 40, "b_first_batch");
        repeat (5) tick();
        check("b_held_count", 64'(wr_cnt1), 64'd8);
        check("b_batch_done", 64'(batch_done1), 64'd1);
        check("b_wr_en_held", 64'(wr_en1), 64'd0);
        check("b_busy_held", 64'(busy1), 64'd1);
        check("b_overflow", 64'(overflow1), 64'd0);
        host_ack1 = 1'b1;
        tick();
        host_ack1 = 1'b0;
        check("b_done_drop", 64'(batch_done1), 64'd0);
        wait_q(1, 0, 20, "b_after_ack");
        check("b_total_count", 64'(wr_cnt1), 64'd10);
        repeat (2) tick();
        check("b_busy_end", 64'(busy1), 64'd0);

        check("end_q0_empty", 64'(exp_q0.size()), 64'd0);
        check("end_q1_empty", 64'(exp_q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
